// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ requesters; optional WAIT timeout via I2C_ARB_TIMEOUT_EN.
// Latency: gnt/m_en one cycle after req is sampled in IDLE; done one cycle after m_done; next grant >= 3 cycles after m_done.
// Backpressure: requesters hold req and fields until gnt; no new grant while busy.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [7*NUM_REQ-1:0]    req_slave_addr,
    input  logic [NUM_REQ-1:0]      req_rw,
    input  logic [8*NUM_REQ-1:0]    req_reg_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [31:0]             rdata,
    output logic                    err,
    output logic                    busy,
    output logic                    m_en,
    output logic [6:0]              m_slave_addr,
    output logic                    m_rw,
    output logic [7:0]              m_reg_addr,
    output logic [31:0]             m_wdata,
    input  logic [31:0]             m_rdata,
    input  logic                    m_done,
    input  logic                    m_nack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("i2c_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        COMPLETE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_nxt;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0]        wait_cnt;
`endif

    // Scan downward in priority so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign rr_nxt = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            m_en         <= 1'b0;
            m_slave_addr <= '0;
            m_rw         <= 1'b0;
            m_reg_addr   <= '0;
            m_wdata      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        owner        <= sel_idx;
                        rr_ptr       <= rr_nxt;
                        gnt          <= NUM_REQ'(1) << sel_idx;
                        m_slave_addr <= req_slave_addr[int'(sel_idx)*7 +: 7];
                        m_rw         <= req_rw[sel_idx];
                        m_reg_addr   <= req_reg_addr[int'(sel_idx)*8 +: 8];
                        m_wdata      <= req_wdata[int'(sel_idx)*32 +: 32];
                        m_en         <= 1'b1;
                        busy         <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        if (m_rw) begin
                            rdata <= m_rdata;
                        end
                        err   <= m_nack;
                        m_en  <= 1'b0;
                        done  <= NUM_REQ'(1) << owner;
                        state <= COMPLETE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    // Count holds the index of the current WAIT cycle, so the last allowed cycle is limit-1.
                    else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        m_en  <= 1'b0;
                        done  <= NUM_REQ'(1) << owner;
                        state <= COMPLETE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                COMPLETE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; timeout scenario runs only with I2C_ARB_TIMEOUT_EN defined.
module tb_i2c_master_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [27:0]  req_slave_addr;
    logic [3:0]   req_rw;
    logic [31:0]  req_reg_addr;
    logic [127:0] req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [31:0]  rdata;
    logic         err;
    logic         busy;
    logic         m_en;
    logic [6:0]   m_slave_addr;
    logic         m_rw;
    logic [7:0]   m_reg_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_done;
    logic         m_nack;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int DONE_DLY = 10;
`else
    localparam int DONE_DLY = 20;
`endif

    always #5 clk = ~clk;

    i2c_master_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_slave_addr (req_slave_addr),
        .req_rw         (req_rw),
        .req_reg_addr   (req_reg_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .done           (done),
        .rdata          (rdata),
        .err            (err),
        .busy           (busy),
        .m_en           (m_en),
        .m_slave_addr   (m_slave_addr),
        .m_rw           (m_rw),
        .m_reg_addr     (m_reg_addr),
        .m_wdata        (m_wdata),
        .m_rdata        (m_rdata),
        .m_done         (m_done),
        .m_nack         (m_nack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic [6:0] a, input logic rw,
                              input logic [7:0] r, input logic [31:0] d);
        req_slave_addr[i*7 +: 7] = a;
        req_rw[i]                = rw;
        req_reg_addr[i*8 +: 8]   = r;
        req_wdata[i*32 +: 32]    = d;
    endtask

    task automatic init_fields();
        for (int i = 0; i < 4; i++) begin
            set_fields(i, 7'h40 + 7'(i), 1'b0, 8'h80 + 8'(i), 32'hC0DE_0000 + 32'(i));
        end
    endtask

    task automatic wait_gnt(output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (gnt != 4'b0000) begin
                ok     = 1'b1;
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        req     = '0;
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_rdata = '0;
        init_fields();
        repeat (2) tick();
        tests_run++; if (gnt !== 4'b0) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        tests_run++; if (done !== 4'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0000", done); end
        tests_run++; if ({rdata, err, busy, m_en} !== 35'b0) begin tests_failed++;
            $display("FAIL reset_status: rdata=%h err=%b busy=%b m_en=%b want all 0", rdata, err, busy, m_en); end
        tests_run++; if ({m_slave_addr, m_rw, m_reg_addr, m_wdata} !== 48'b0) begin tests_failed++;
            $display("FAIL reset_fields: addr=%h rw=%b reg=%h wdata=%h want all 0", m_slave_addr, m_rw, m_reg_addr, m_wdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        set_fields(2, 7'h50, 1'b0, 8'h10, 32'hA5A5_0001);
        req = 4'b0100;
        tick();
        tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL wr_gnt: got %b want 0100", gnt); end
        tests_run++; if ({m_en, busy} !== 2'b11) begin tests_failed++; $display("FAIL wr_en_busy: got m_en=%b busy=%b want 1 1", m_en, busy); end
        tests_run++; if ({m_slave_addr, m_rw, m_reg_addr, m_wdata} !== {7'h50, 1'b0, 8'h10, 32'hA5A5_0001}) begin tests_failed++;
            $display("FAIL wr_fields: got addr=%h rw=%b reg=%h wdata=%h want 50 0 10 a5a50001", m_slave_addr, m_rw, m_reg_addr, m_wdata); end
        req = 4'b0000;
        tick();
        tests_run++; if ({gnt, m_en} !== 5'b0000_1) begin tests_failed++; $display("FAIL wr_launch: got gnt=%b m_en=%b want 0000 1", gnt, m_en); end
        m_rdata = 32'hFFFF_FFFF;
        m_nack  = 1'b0;
        m_done  = 1'b1;
        tick();
        m_done  = 1'b0;
        tests_run++; if (done !== 4'b0100) begin tests_failed++; $display("FAIL wr_done: got %b want 0100", done); end
        tests_run++; if ({err, rdata} !== 33'h0_0000_0000) begin tests_failed++; $display("FAIL wr_status: got err=%b rdata=%h want 0 00000000", err, rdata); end
        tests_run++; if ({m_en, busy} !== 2'b01) begin tests_failed++; $display("FAIL wr_complete: got m_en=%b busy=%b want 0 1", m_en, busy); end
        tick();
        tests_run++; if ({done, busy} !== 5'b0000_0) begin tests_failed++; $display("FAIL wr_idle: got done=%b busy=%b want 0000 0", done, busy); end
    endtask

    task automatic test_read_nack();
        set_fields(0, 7'h21, 1'b1, 8'h33, 32'h0);
        req = 4'b0001;
        tick();
        tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL rd_gnt: got %b want 0001", gnt); end
        tests_run++; if ({m_slave_addr, m_rw, m_reg_addr} !== {7'h21, 1'b1, 8'h33}) begin tests_failed++;
            $display("FAIL rd_fields: got addr=%h rw=%b reg=%h want 21 1 33", m_slave_addr, m_rw, m_reg_addr); end
        req = 4'b0000;
        repeat (3) tick();
        m_rdata = 32'h1234_5678;
        m_nack  = 1'b1;
        m_done  = 1'b1;
        tick();
        m_done  = 1'b0;
        m_nack  = 1'b0;
        tests_run++; if (done !== 4'b0001) begin tests_failed++; $display("FAIL rd_done: got %b want 0001", done); end
        tests_run++; if (rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rd_rdata: got %h want 12345678", rdata); end
        tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL rd_err: got %b want 1", err); end
        tick();
    endtask

    task automatic test_spurious_done();
        m_rdata = 32'hDEAD_BEEF;
        m_nack  = 1'b0;
        m_done  = 1'b1;
        tick();
        m_done  = 1'b0;
        tests_run++; if ({done, gnt, busy, m_en} !== 10'b0) begin tests_failed++;
            $display("FAIL spur_ctrl: got done=%b gnt=%b busy=%b m_en=%b want all 0", done, gnt, busy, m_en); end
        tests_run++; if ({rdata, err} !== {32'h1234_5678, 1'b1}) begin tests_failed++;
            $display("FAIL spur_status: got rdata=%h err=%b want 12345678 1", rdata, err); end
        repeat (2) tick();
        tests_run++; if (done !== 4'b0) begin tests_failed++; $display("FAIL spur_late_done: got %b want 0000", done); end
    endtask

    task automatic test_reset_mid_wait();
        int  cyc;
        bit  ok;
        set_fields(1, 7'h2A, 1'b1, 8'h44, 32'h0);
        req = 4'b0010;
        tick();
        tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL rst_pre_gnt: got %b want 0010", gnt); end
        req = 4'b0000;
        repeat (3) tick();
        tests_run++; if (m_en !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_en: got %b want 1", m_en); end
        rst = 1'b0;
        #1;
        tests_run++; if (m_en !== 1'b0) begin tests_failed++; $display("FAIL rst_async_en: got %b want 0", m_en); end
        tests_run++; if ({gnt, done, rdata, busy} !== 41'b0) begin tests_failed++;
            $display("FAIL rst_async_out: got gnt=%b done=%b rdata=%h busy=%b want all 0", gnt, done, rdata, busy); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tests_run++; if ({done, m_en} !== 5'b0) begin tests_failed++; $display("FAIL rst_no_done: got done=%b m_en=%b want 0000 0", done, m_en); end
        init_fields();
        req = 4'b1111;
        wait_gnt(cyc, ok);
        req = 4'b0000;
        tests_run++; if (!ok || gnt !== 4'b0001) begin tests_failed++; $display("FAIL rst_regrant: got gnt=%b ok=%0d want 0001", gnt, ok); end
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int         cyc;
        bit         ok;
        int         idx;
        logic [3:0] exp;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        init_fields();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            idx = g % 4;
            exp = 4'b0001 << idx;
            wait_gnt(cyc, ok);
            tests_run++; if (!ok || gnt !== exp) begin tests_failed++; $display("FAIL cont_gnt%0d: got %b want %b", g, gnt, exp); end
            if (g > 0) begin
                tests_run++; if (cyc !== 2) begin tests_failed++; $display("FAIL cont_lat%0d: got %0d cycles want 2", g, cyc); end
            end
            tests_run++; if ({m_slave_addr, m_wdata} !== {7'h40 + 7'(idx), 32'hC0DE_0000 + 32'(idx)}) begin tests_failed++;
                $display("FAIL cont_fields%0d: got addr=%h wdata=%h", g, m_slave_addr, m_wdata); end
            repeat (DONE_DLY) tick();
            tests_run++; if ({m_en, m_reg_addr} !== {1'b1, 8'h80 + 8'(idx)}) begin tests_failed++;
                $display("FAIL cont_hold%0d: got m_en=%b reg=%h want 1 %h", g, m_en, m_reg_addr, 8'h80 + 8'(idx)); end
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            tests_run++; if (done !== exp) begin tests_failed++; $display("FAIL cont_done%0d: got %b want %b", g, done, exp); end
        end
        req = 4'b0000;
        repeat (2) tick();
        tests_run++; if ({gnt, busy} !== 5'b0) begin tests_failed++; $display("FAIL cont_quiet: got gnt=%b busy=%b want 0000 0", gnt, busy); end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rdata_before;
        rdata_before = rdata;
        req = 4'b0100;
        tick();
        tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL to_gnt: got %b want 0100", gnt); end
        req = 4'b0000;
        for (int k = 1; k <= 16; k++) tick();
        tests_run++; if ({done, m_en} !== 5'b0000_1) begin tests_failed++; $display("FAIL to_early: got done=%b m_en=%b want 0000 1", done, m_en); end
        tick();
        tests_run++; if (done !== 4'b0100) begin tests_failed++; $display("FAIL to_done: got %b want 0100", done); end
        tests_run++; if ({err, m_en} !== 2'b10) begin tests_failed++; $display("FAIL to_status: got err=%b m_en=%b want 1 0", err, m_en); end
        tests_run++; if (rdata !== rdata_before) begin tests_failed++; $display("FAIL to_rdata: got %h want %h", rdata, rdata_before); end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_nack();
        test_spurious_done();
        test_reset_mid_wait();
        test_contention();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
